// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Front-end PC controller. It drives the fetch unit's PCin/PCWrite pair and
//   sequences four kinds of fetch: sequential, hazard stall, branch redirect
//   with an IF/ID flush window, and halt on an out-of-range address.
//   All outputs are registered. Addresses are word addresses (next = pc+1).
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   stall_i         hazard stall request; hold the PC
//   branch_taken_i  branch resolved taken this cycle
//   branch_target_i word address of the branch target
//   pc_out          word address to the fetch unit (PCin)
//   pc_write        PCWrite enable to the fetch unit
//   fetch_valid     the instruction fetched at pc_out is architecturally valid
//   if_flush        kill the IF/ID register contents
//   halted          sequencer stopped on an out-of-range address
//   fetch_count     saturating count of valid fetch cycles
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int PC_WIDTH     = 32,
  parameter int IMEM_DEPTH   = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_i,
  input  logic                 branch_taken_i,
  input  logic [PC_WIDTH-1:0]  branch_target_i,
  output logic [PC_WIDTH-1:0]  pc_out,
  output logic                 pc_write,
  output logic                 fetch_valid,
  output logic                 if_flush,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    RUN   = 3'd1,
    STALL = 3'd2,
    FLUSH = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam logic [PC_WIDTH-1:0] LAST_PC    = PC_WIDTH'(IMEM_DEPTH - 1);
  // Compare one bit wider so a depth of 2**PC_WIDTH does not wrap to zero.
  localparam logic [PC_WIDTH:0]   DEPTH_EXT  = (PC_WIDTH+1)'(IMEM_DEPTH);
  localparam logic [2:0]          FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t              state;
  logic [2:0]          flushCnt;

  logic                tgtInRange;
  logic                atLast;
  logic                cntSat;
  logic [PC_WIDTH-1:0] pcNext;

  assign tgtInRange = ({1'b0, branch_target_i} < DEPTH_EXT);
  assign atLast     = (pc_out == LAST_PC);
  assign cntSat     = &fetch_count;
  assign pcNext     = pc_out + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT;
      flushCnt    <= '0;
      pc_out      <= '0;
      pc_write    <= 1'b0;
      fetch_valid <= 1'b0;
      if_flush    <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      // Counts the fetch presented during the cycle that just ended.
      if (fetch_valid && pc_write && !cntSat)
        fetch_count <= fetch_count + 1'b1;

      case (state)
        INIT: begin
          state       <= RUN;
          pc_write    <= 1'b1;
          fetch_valid <= 1'b1;
        end

        RUN, STALL, FLUSH: begin
          if (branch_taken_i) begin
            // A branch beats a stall and also re-arms an ongoing flush.
            if (!tgtInRange) begin
              state       <= HALT;
              pc_write    <= 1'b0;
              fetch_valid <= 1'b0;
              if_flush    <= 1'b0;
              halted      <= 1'b1;
            end else begin
              state       <= FLUSH;
              pc_out      <= branch_target_i;
              pc_write    <= 1'b1;
              fetch_valid <= 1'b0;
              if_flush    <= 1'b1;
              flushCnt    <= FLUSH_LOAD;
            end
          end else if (stall_i && state != FLUSH) begin
            // Hold PC; fetch_valid is already 1 in RUN and STALL.
            state    <= STALL;
            pc_write <= 1'b0;
          end else if (atLast) begin
            state       <= HALT;
            pc_write    <= 1'b0;
            fetch_valid <= 1'b0;
            if_flush    <= 1'b0;
            halted      <= 1'b1;
          end else begin
            pc_out   <= pcNext;
            pc_write <= 1'b1;
            if (state == FLUSH) begin
              // flushCnt==0 marks the last flushed cycle; leave on this edge.
              if (flushCnt == 3'd0) begin
                state       <= RUN;
                if_flush    <= 1'b0;
                fetch_valid <= 1'b1;
              end else begin
                flushCnt <= flushCnt - 3'd1;
              end
            end else begin
              state <= RUN;
            end
          end
        end

        HALT: begin
          // Sticky until reset; outputs were set on entry.
          pc_write    <= 1'b0;
          fetch_valid <= 1'b0;
          if_flush    <= 1'b0;
          halted      <= 1'b1;
        end

        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int PCW   = 32;
  localparam int DEPTH = 32;
  localparam int FLC   = 2;
  localparam int CW    = 4;   // small counter so saturation is reached quickly
  localparam int CMAX  = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           stI, brI;
  logic [PCW-1:0] tgtI;
  logic [PCW-1:0] pc_out;
  logic           pc_write, fetch_valid, if_flush, halted;
  logic [CW-1:0]  fetch_count;

  int nAssert = 0;
  int nFail   = 0;

  // Reference model: outputs plus "started" and flush cycles remaining.
  int mPc, mCnt, mFlushLeft;
  bit mPw, mFv, mFl, mHalt, mStarted;

  pc_sequencer #(.PC_WIDTH(PCW), .IMEM_DEPTH(DEPTH), .FLUSH_CYCLES(FLC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stI), .branch_taken_i(brI),
    .branch_target_i(tgtI), .pc_out(pc_out), .pc_write(pc_write),
    .fetch_valid(fetch_valid), .if_flush(if_flush), .halted(halted),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkAll(input string tag);
    chk({tag, ".pc"},     pc_out,      mPc);
    chk({tag, ".pw"},     pc_write,    32'(mPw));
    chk({tag, ".fv"},     fetch_valid, 32'(mFv));
    chk({tag, ".flush"},  if_flush,    32'(mFl));
    chk({tag, ".halted"}, halted,      32'(mHalt));
    chk({tag, ".cnt"},    fetch_count, mCnt);
  endtask

  task automatic mReset();
    mPc = 0; mCnt = 0; mFlushLeft = 0;
    mPw = 0; mFv = 0; mFl = 0; mHalt = 0; mStarted = 0;
  endtask

  task automatic mGoHalt();
    mHalt = 1; mPw = 0; mFv = 0; mFl = 0; mFlushLeft = 0;
  endtask

  task automatic mRedirect(input int t);
    if (t >= DEPTH) mGoHalt();
    else begin
      mPc = t; mPw = 1; mFv = 0; mFl = 1; mFlushLeft = FLC;
    end
  endtask

  // One clock edge of the specified behaviour.
  task automatic mEdge(input bit st, input bit br, input int t);
    if (mFv && mPw && mCnt < CMAX) mCnt++;
    if (!mStarted) begin
      mStarted = 1; mPw = 1; mFv = 1;
    end else if (mHalt) begin
    end else if (mFlushLeft > 0) begin
      if (br) mRedirect(t);
      else if (mPc == DEPTH - 1) mGoHalt();
      else begin
        mPc++; mFlushLeft--;
        if (mFlushLeft == 0) begin mFl = 0; mFv = 1; end
      end
    end else begin
      if (br) mRedirect(t);
      else if (st) mPw = 0;
      else if (mPc == DEPTH - 1) mGoHalt();
      else begin mPc++; mPw = 1; end
    end
  endtask

  task automatic step(input bit st, input bit br, input int t, input string tag);
    stI = st; brI = br; tgtI = PCW'(t);
    @(posedge clk);
    mEdge(st, br, t);
    #1;
    chkAll(tag);
  endtask

  // Async reset between edges, checked before any clock edge arrives.
  task automatic doReset(input string tag);
    #2 rst_n = 1'b0;
    stI = 0; brI = 0; tgtI = '0;
    #1;
    mReset();
    chkAll(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    int haltRun;
    rst_n = 1'b0; stI = 0; brI = 0; tgtI = '0;
    mReset();
    #2;
    chkAll("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch from INIT.
    for (int i = 0; i < 5; i++) step(0, 0, 0, "seq");
    chk("seq.pc4", pc_out, 32'd4);
    chk("seq.cnt4", fetch_count, 32'd4);
    step(0, 0, 0, "seq5");

    // Three stall cycles at pc 5.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, "stall");
      chk("stall.pw0", pc_write, 32'd0);
    end
    step(0, 0, 0, "unstall");
    chk("unstall.pc6", pc_out, 32'd6);
    step(0, 0, 0, "seq7");

    // Branch to 12 with a two-cycle flush.
    step(0, 1, 12, "br12");
    chk("br12.pc", pc_out, 32'd12);
    step(0, 0, 0, "flush13");
    chk("flush13.fl", if_flush, 32'd1);
    step(0, 0, 0, "flushEnd");
    chk("flushEnd.pc14", pc_out, 32'd14);
    chk("flushEnd.fv", fetch_valid, 32'd1);

    // Branch together with stall: branch wins.
    step(1, 1, 3, "brStall");
    chk("brStall.pc3", pc_out, 32'd3);
    step(1, 0, 0, "brStallFl");
    step(1, 0, 0, "brStallFl2");

    // Run to the last word and halt.
    guard = 0;
    while (!mHalt && guard < 64) begin
      step(0, 0, 0, "toEnd");
      guard++;
    end
    chk("toEnd.bound", 32'(mHalt), 32'd1);
    chk("toEnd.pc31", pc_out, 32'd31);
    step(0, 1, 40, "haltBr40");
    step(1, 0, 0, "haltHold");

    // Out-of-range branch from RUN.
    doReset("rst2");
    for (int i = 0; i < 3; i++) step(0, 0, 0, "seqB");
    step(0, 1, 40, "br40");
    chk("br40.halted", halted, 32'd1);
    chk("br40.pc2", pc_out, 32'd2);

    // Reset landing in the middle of a flush, then restart.
    doReset("rst3");
    for (int i = 0; i < 3; i++) step(0, 0, 0, "seqC");
    step(0, 1, 20, "br20");
    step(0, 1, 25, "rebr25");
    doReset("rstMidFlush");
    for (int i = 0; i < 3; i++) step(0, 0, 0, "restart");

    // Randomized traffic against the model.
    haltRun = 0;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0),
           int'($urandom_range(0, 39)), "rnd");
      if (mHalt) haltRun++;
      if (haltRun > 3) begin
        haltRun = 0;
        doReset("rndRst");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
